// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset controller: Moore main FSM plus ALU and immediate decoders.
// Optional build macro MC_ILLEGAL_TRAP_EN: unsupported opcodes trap in ILLEGAL until reset.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [3:0] State,
  output logic       Illegal
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  state_t     state, next;
  logic       pcupdate, branch;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_comb begin
    next = FETCH;
    case (state)
      FETCH:  next = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next = MEMADR;
          OP_RTYPE:          next = EXECUTER;
          OP_ITYPE:          next = EXECUTEI;
          OP_JAL:            next = JAL;
          OP_BEQ:            next = BEQ;
`ifdef MC_ILLEGAL_TRAP_EN
          default:           next = ILLEGAL;
`else
          default:           next = FETCH;
`endif
        endcase
      end
      MEMADR:   next = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  next = MEMWB;
      EXECUTER: next = ALUWB;
      EXECUTEI: next = ALUWB;
      JAL:      next = ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
      ILLEGAL:  next = ILLEGAL;
`endif
      // MEMWB, MEMWRITE, ALUWB, BEQ and unused codes 12-15 all return to FETCH
      default:  next = FETCH;
    endcase
  end

  always_comb begin
    pcupdate  = 1'b0;
    branch    = 1'b0;
    aluop     = 2'b00;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pcupdate  = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b10;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = 2'b10;
      end
      ALUWB: RegWrite = 1'b1;
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite = pcupdate | (branch & Zero);

  always_comb begin
    ALUControl = 3'b000;
    case (aluop)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE: ImmSrc = 2'b01;
      OP_BEQ:   ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  assign State = state;

`ifdef MC_ILLEGAL_TRAP_EN
  assign Illegal = (state == ILLEGAL);
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction vector table, per-cycle scoreboard.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .State(State), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluctl;
    logic [1:0] immsrc;
    logic [3:0] state;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        zero;
    int unsigned len;
    logic [23:0] path;   // nibble i = expected state in cycle i
    logic [2:0]  alu;    // ALUControl expected in EXECUTER/EXECUTEI
    logic [1:0]  imm;
  } vec_t;

  ctl_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Expected Moore outputs per state, straight from the state/output table.
  function automatic ctl_t exp_out(input logic [3:0] s, input logic z,
                                   input logic [2:0] alu, input logic [1:0] imm);
    ctl_t e;
    e = '0;
    e.state  = s;
    e.immsrc = imm;
    case (s)
      4'd0:  begin e.pcwrite = 1'b1; e.irwrite = 1'b1; e.alusrcb = 2'b10; e.resultsrc = 2'b10; end
      4'd1:  begin e.alusrca = 2'b01; e.alusrcb = 2'b01; end
      4'd2:  begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
      4'd3:  e.adrsrc = 1'b1;
      4'd4:  begin e.resultsrc = 2'b01; e.regwrite = 1'b1; end
      4'd5:  begin e.adrsrc = 1'b1; e.memwrite = 1'b1; end
      4'd6:  begin e.alusrca = 2'b10; e.aluctl = alu; end
      4'd7:  e.regwrite = 1'b1;
      4'd8:  begin e.alusrca = 2'b10; e.alusrcb = 2'b01; e.aluctl = alu; end
      4'd9:  begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcwrite = 1'b1; end
      4'd10: begin e.alusrca = 2'b10; e.aluctl = 3'b001; e.pcwrite = z; end
      4'd11: e.illegal = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctl_t sample();
    ctl_t a;
    a.pcwrite   = PCWrite;
    a.adrsrc    = AdrSrc;
    a.memwrite  = MemWrite;
    a.irwrite   = IRWrite;
    a.regwrite  = RegWrite;
    a.resultsrc = ResultSrc;
    a.alusrca   = ALUSrcA;
    a.alusrcb   = ALUSrcB;
    a.aluctl    = ALUControl;
    a.immsrc    = ImmSrc;
    a.state     = State;
    a.illegal   = Illegal;
    return a;
  endfunction

  // Push expectation, compare at the falling edge, return 1 time unit after the next rising edge.
  task automatic do_cycle(input ctl_t e, input string tag);
    ctl_t x, a;
    expq.push_back(e);
    @(negedge clk);
    x = expq.pop_front();
    a = sample();
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", tag, a, a.state, x, x.state);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [3:0] s;

    //           op          f3      f7    zero  len path        alu     imm
    tbl.push_back('{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 24'h043210, 3'b000, 2'b00}); // lw
    tbl.push_back('{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 24'h005210, 3'b000, 2'b01}); // sw
    tbl.push_back('{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 24'h007610, 3'b001, 2'b00}); // sub
    tbl.push_back('{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 24'h007810, 3'b000, 2'b00}); // addi, bit30 set
    tbl.push_back('{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 24'h007610, 3'b000, 2'b00}); // add
    tbl.push_back('{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 24'h007610, 3'b101, 2'b00}); // slt
    tbl.push_back('{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 24'h007610, 3'b011, 2'b00}); // or
    tbl.push_back('{7'b0010011, 3'b111, 1'b0, 1'b0, 4, 24'h007810, 3'b010, 2'b00}); // andi
    tbl.push_back('{7'b0110011, 3'b001, 1'b1, 1'b0, 4, 24'h007610, 3'b000, 2'b00}); // sll -> add
    tbl.push_back('{7'b1101111, 3'b000, 1'b0, 1'b0, 4, 24'h007910, 3'b000, 2'b11}); // jal
    tbl.push_back('{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 24'h000A10, 3'b000, 2'b10}); // beq taken
    tbl.push_back('{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 24'h000A10, 3'b000, 2'b10}); // beq not taken
`ifndef MC_ILLEGAL_TRAP_EN
    tbl.push_back('{7'b0000000, 3'b000, 1'b0, 1'b0, 2, 24'h000010, 3'b000, 2'b00}); // unsupported op
`endif

    op = 7'b0000011; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_cycle(exp_out(4'd0, 1'b0, 3'b000, 2'b00), "reset_state");
    reset = 1'b0;

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.zero;
      for (int unsigned c = 0; c < v.len; c++) begin
        s = v.path[4*c +: 4];
        do_cycle(exp_out(s, v.zero, v.alu, v.imm), $sformatf("vec%0d_cyc%0d", i, c));
      end
    end

    // Zero flips while in BEQ: PCWrite must follow within the same cycle.
    op = 7'b1100011; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
    do_cycle(exp_out(4'd0, 1'b0, 3'b000, 2'b10), "beqflip_fetch");
    do_cycle(exp_out(4'd1, 1'b0, 3'b000, 2'b10), "beqflip_decode");
    Zero = 1'b1;
    do_cycle(exp_out(4'd10, 1'b1, 3'b000, 2'b10), "beqflip_zero1");
    Zero = 1'b0;

    // Reset during MEMREAD aborts the load before any register write.
    op = 7'b0000011; funct3 = 3'b010;
    do_cycle(exp_out(4'd0, 1'b0, 3'b000, 2'b00), "ldabort_fetch");
    do_cycle(exp_out(4'd1, 1'b0, 3'b000, 2'b00), "ldabort_decode");
    do_cycle(exp_out(4'd2, 1'b0, 3'b000, 2'b00), "ldabort_memadr");
    reset = 1'b1;
    do_cycle(exp_out(4'd3, 1'b0, 3'b000, 2'b00), "ldabort_memread");
    do_cycle(exp_out(4'd0, 1'b0, 3'b000, 2'b00), "ldabort_fetch_after_reset");
    reset = 1'b0;

`ifdef MC_ILLEGAL_TRAP_EN
    op = 7'b0000000; funct3 = '0;
    do_cycle(exp_out(4'd0, 1'b0, 3'b000, 2'b00), "trap_fetch");
    do_cycle(exp_out(4'd1, 1'b0, 3'b000, 2'b00), "trap_decode");
    for (int unsigned c = 0; c < 10; c++)
      do_cycle(exp_out(4'd11, 1'b0, 3'b000, 2'b00), $sformatf("trap_hold%0d", c));
    reset = 1'b1;
    do_cycle(exp_out(4'd11, 1'b0, 3'b000, 2'b00), "trap_reset_edge");
    do_cycle(exp_out(4'd0, 1'b0, 3'b000, 2'b00), "trap_after_reset");
    reset = 1'b0;
`endif

    // After the aborted load the controller must run a full store normally.
    op = 7'b0100011; funct3 = 3'b010;
    do_cycle(exp_out(4'd0, 1'b0, 3'b000, 2'b01), "post_sw_fetch");
    do_cycle(exp_out(4'd1, 1'b0, 3'b000, 2'b01), "post_sw_decode");
    do_cycle(exp_out(4'd2, 1'b0, 3'b000, 2'b01), "post_sw_memadr");
    do_cycle(exp_out(4'd5, 1'b0, 3'b000, 2'b01), "post_sw_memwrite");
    do_cycle(exp_out(4'd0, 1'b0, 3'b000, 2'b01), "post_sw_back_to_fetch");

    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", expq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
